// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } uart_rx_state_t;

    localparam int unsigned TUSER_W       = 4;
    localparam int unsigned TUSER_PARITY  = 0;
    localparam int unsigned TUSER_FRAMING = 1;
    localparam int unsigned TUSER_OVERRUN = 2;
    localparam int unsigned TUSER_BREAK   = 3;

    // Two-of-three majority used for the mid-bit vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Bit-slot counter with three-point mid-bit majority vote.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic rxd_s,
    output logic bit_c,
    output logic decide_c,
    output logic slot_end_c
);

    localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
    localparam int unsigned MID = (CLKS_PER_BIT - 1) / 2;

    logic [CW-1:0] cnt;
    logic          s_early;
    logic          s_mid;

    // Counter is held at zero while idle so slot 0 starts on the start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            s_early <= 1'b1;
            s_mid   <= 1'b1;
        end else if (!run) begin
            cnt <= '0;
        end else begin
            cnt <= (cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt + CW'(1);
            if (cnt == CW'(MID - 1)) s_early <= rxd_s;
            if (cnt == CW'(MID))     s_mid   <= rxd_s;
        end
    end

    always_comb begin
        decide_c   = run && (cnt == CW'(MID + 1));
        slot_end_c = run && (cnt == CW'(CLKS_PER_BIT - 1));
        bit_c      = maj3(s_early, s_mid, rxd_s);
    end

endmodule

// File: rtl/uart_rx_framed.sv
// Configurable UART receiver with AXI-Stream output, per-frame error flags
// and saturating error counters; never back-pressures the line.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int unsigned  CLKS_PER_BIT = 868,
    parameter int unsigned  DATA_BITS    = 8,
    parameter parity_mode_t PARITY_MODE  = PARITY_NONE,
    parameter int unsigned  STOP_BITS    = 1,
    parameter int unsigned  CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_tdata,
    output logic                 rx_tvalid,
    input  logic                 rx_tready,
    output logic [TUSER_W-1:0]   rx_tuser,
    output logic                 rx_tlast,
    output logic [CNT_WIDTH-1:0] parity_err_count,
    output logic [CNT_WIDTH-1:0] framing_err_count,
    output logic [CNT_WIDTH-1:0] overrun_count,
    output logic                 busy
);

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    uart_rx_state_t       state;
    logic                 rxd_s1;
    logic                 rxd_s;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 framing_acc;
    logic                 overrun_sticky;

    logic                 run_c;
    logic                 bit_c;
    logic                 decide_c;
    logic                 slot_end_c;
    logic                 done_c;
    logic                 framing_c;
    logic                 parity_err_c;
    logic                 break_c;
    logic [TUSER_W-1:0]   flags_c;

    assign rx_tlast = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_s1 <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            rxd_s1 <= rxd;
            rxd_s  <= rxd_s1;
        end
    end

    assign run_c = (state == ST_START) || (state == ST_DATA) ||
                   (state == ST_PARITY) || (state == ST_STOP);

    uart_bit_sampler #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_sampler (
        .clk       (clk),
        .reset     (reset),
        .run       (run_c),
        .rxd_s     (rxd_s),
        .bit_c     (bit_c),
        .decide_c  (decide_c),
        .slot_end_c(slot_end_c)
    );

    // Frame status evaluated at the decision point of the final stop bit.
    always_comb begin
        done_c       = (state == ST_STOP) && decide_c && (stop_idx == 1'(STOP_BITS - 1));
        framing_c    = framing_acc | ~bit_c;
        parity_err_c = 1'b0;
        if (PARITY_MODE == PARITY_EVEN) parity_err_c = (^shreg) ^ par_bit;
        if (PARITY_MODE == PARITY_ODD)  parity_err_c = ~((^shreg) ^ par_bit);
        break_c = (shreg == '0) && ((PARITY_MODE == PARITY_NONE) || !par_bit) && framing_c;
        flags_c                = '0;
        flags_c[TUSER_PARITY]  = parity_err_c;
        flags_c[TUSER_FRAMING] = framing_c;
        flags_c[TUSER_OVERRUN] = overrun_sticky;
        flags_c[TUSER_BREAK]   = break_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            framing_acc <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state       <= ST_START;
                        busy        <= 1'b1;
                        framing_acc <= 1'b0;
                        par_bit     <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide_c && bit_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (slot_end_c) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (decide_c) shreg[bit_idx] <= bit_c;
                    if (slot_end_c) begin
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            state    <= (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
                            stop_idx <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide_c)   par_bit <= bit_c;
                    if (slot_end_c) state   <= ST_STOP;
                end
                ST_STOP: begin
                    // Complete mid-bit on the last stop bit so back-to-back frames resync.
                    if (done_c) begin
                        state <= break_c ? ST_BREAK_WAIT : ST_IDLE;
                        busy  <= break_c;
                    end else begin
                        if (decide_c)   framing_acc <= framing_c;
                        if (slot_end_c) stop_idx    <= 1'b1;
                    end
                end
                ST_BREAK_WAIT: begin
                    if (rxd_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Single-entry output register; a frame arriving while it is still held is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_tvalid         <= 1'b0;
            rx_tdata          <= '0;
            rx_tuser          <= '0;
            overrun_sticky    <= 1'b0;
            parity_err_count  <= '0;
            framing_err_count <= '0;
            overrun_count     <= '0;
        end else begin
            if (rx_tvalid && rx_tready) rx_tvalid <= 1'b0;
            if (done_c) begin
                if (parity_err_c && (parity_err_count != '1))
                    parity_err_count <= parity_err_count + CNT_WIDTH'(1);
                if (framing_c && (framing_err_count != '1))
                    framing_err_count <= framing_err_count + CNT_WIDTH'(1);
                if (rx_tvalid && !rx_tready) begin
                    overrun_sticky <= 1'b1;
                    if (overrun_count != '1) overrun_count <= overrun_count + CNT_WIDTH'(1);
                end else begin
                    rx_tvalid      <= 1'b1;
                    rx_tdata       <= shreg;
                    rx_tuser       <= flags_c;
                    overrun_sticky <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: an 8N1 instance and an 8E1 instance at 16 clocks/bit.
module tb_uart_rx_framed;
    import uart_pkg::*;

    localparam int unsigned CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        rxd_n = 1'b1, rxd_e = 1'b1;
    logic        tready_n = 1'b1, tready_e = 1'b1;
    logic [7:0]  data_n, data_e;
    logic        tvalid_n, tvalid_e, tlast_n, tlast_e, busy_n, busy_e;
    logic [3:0]  tuser_n, tuser_e;
    logic [15:0] pe_n, fe_n, ov_n, pe_e, fe_e, ov_e;

    uart_rx_framed #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PARITY_NONE), .STOP_BITS(1), .CNT_WIDTH(16)
    ) dut_n (
        .clk(clk), .reset(reset), .rxd(rxd_n),
        .rx_tdata(data_n), .rx_tvalid(tvalid_n), .rx_tready(tready_n),
        .rx_tuser(tuser_n), .rx_tlast(tlast_n),
        .parity_err_count(pe_n), .framing_err_count(fe_n), .overrun_count(ov_n),
        .busy(busy_n)
    );

    uart_rx_framed #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(PARITY_EVEN), .STOP_BITS(1), .CNT_WIDTH(16)
    ) dut_e (
        .clk(clk), .reset(reset), .rxd(rxd_e),
        .rx_tdata(data_e), .rx_tvalid(tvalid_e), .rx_tready(tready_e),
        .rx_tuser(tuser_e), .rx_tlast(tlast_e),
        .parity_err_count(pe_e), .framing_err_count(fe_e), .overrun_count(ov_e),
        .busy(busy_e)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_n = 0, fall_n = 0;
    int nout_n = 0;
    logic prev_n = 1'b0;
    logic [11:0] exp_n[$];
    logic [11:0] exp_e[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected {tuser,data} on every accepted beat.
    always @(negedge clk) begin : mon_n
        logic [11:0] e;
        if (tvalid_n && !prev_n) rise_n = cyc;
        if (!tvalid_n && prev_n) fall_n = cyc;
        prev_n = tvalid_n;
        if (!reset && tvalid_n && tready_n) begin
            nout_n++;
            if (exp_n.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_n_unexpected: got data 0x%0h tuser 0x%0h, expected no output",
                         data_n, tuser_n);
            end else begin
                e = exp_n.pop_front();
                check("out_n", {19'd0, tlast_n, tuser_n, data_n}, {19'd0, 1'b1, e});
            end
        end
    end

    always @(negedge clk) begin : mon_e
        logic [11:0] e;
        if (!reset && tvalid_e && tready_e) begin
            if (exp_e.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_e_unexpected: got data 0x%0h tuser 0x%0h, expected no output",
                         data_e, tuser_e);
            end else begin
                e = exp_e.pop_front();
                check("out_e", {19'd0, tlast_e, tuser_e, data_e}, {19'd0, 1'b1, e});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive n bit slots LSB first; optionally invert the line for one clock at mid-bit of slot spike_bit.
    task automatic drive(input bit which, input logic [15:0] bits, input int n, input int spike_bit);
        logic v;
        for (int b = 0; b < n; b++) begin
            for (int j = 0; j < int'(CPB); j++) begin
                @(negedge clk);
                v = bits[b];
                if (b == spike_bit && j == 8) v = ~v;
                if (which) rxd_e = v;
                else       rxd_n = v;
                if (b == 0 && j == 0) start_cyc = cyc + 1;
            end
        end
    endtask

    task automatic send_n(input logic [7:0] d, input logic stop, input int spike_bit);
        drive(1'b0, {6'd0, stop, d, 1'b0}, 10, spike_bit);
    endtask

    task automatic send_e(input logic [7:0] d, input logic par);
        drive(1'b1, {5'd0, 1'b1, par, d, 1'b0}, 11, -1);
    endtask

    task automatic check_reset_n(input string tag);
        check({tag, "_tvalid"}, {31'd0, tvalid_n}, 32'd0);
        check({tag, "_tdata"},  {24'd0, data_n}, 32'd0);
        check({tag, "_tuser"},  {28'd0, tuser_n}, 32'd0);
        check({tag, "_counts"}, {pe_n, fe_n | ov_n}, 32'd0);
        check({tag, "_busy"},   {31'd0, busy_n}, 32'd0);
    endtask

    logic [15:0] snap_pe, snap_fe, snap_ov;
    int snap_out;

    initial begin
        idle(4);
        check_reset_n("rst0");
        check("rst0_e", {30'd0, tvalid_e, busy_e}, 32'd0);
        reset = 1'b0;
        idle(10);

        // Basic 8N1 byte with latency and single-cycle valid.
        exp_n.push_back({4'b0000, 8'hA5});
        send_n(8'hA5, 1'b1, -1);
        idle(20);
        check("latency", rise_n - start_cyc, 2 + 9 * 16 + 8 + 1);
        check("valid_width", fall_n - rise_n, 1);

        // Even parity, good then bad.
        exp_e.push_back({4'b0000, 8'h07});
        send_e(8'h07, 1'b1);
        exp_e.push_back({4'b0001, 8'h07});
        send_e(8'h07, 1'b0);
        check("parity_count", {16'd0, pe_e}, 32'd1);
        idle(20);

        // Framing error: stop bit low.
        exp_n.push_back({4'b0010, 8'h3C});
        send_n(8'h3C, 1'b0, -1);
        rxd_n = 1'b1;
        idle(40);
        check("framing_count", {16'd0, fe_n}, 32'd1);

        // Break: line low for two frame times.
        exp_n.push_back({4'b1010, 8'h00});
        @(negedge clk);
        rxd_n = 1'b0;
        idle(200);
        check("break_busy_mid", {31'd0, busy_n}, 32'd1);
        idle(120);
        check("break_busy_end", {31'd0, busy_n}, 32'd1);
        rxd_n = 1'b1;
        idle(5);
        check("break_busy_release", {31'd0, busy_n}, 32'd0);
        check("break_framing_count", {16'd0, fe_n}, 32'd2);
        idle(20);
        exp_n.push_back({4'b0000, 8'h55});
        send_n(8'h55, 1'b1, -1);
        idle(20);

        // Overrun: three frames with the sink stalled.
        @(posedge clk); #1 tready_n = 1'b0;
        exp_n.push_back({4'b0000, 8'h11});
        send_n(8'h11, 1'b1, -1);
        send_n(8'h22, 1'b1, -1);
        send_n(8'h33, 1'b1, -1);
        idle(10);
        check("overrun_count", {16'd0, ov_n}, 32'd2);
        check("overrun_held", {23'd0, tvalid_n, data_n}, {23'd0, 1'b1, 8'h11});
        @(posedge clk); #1 tready_n = 1'b1;
        idle(10);
        exp_n.push_back({4'b0100, 8'h44});
        send_n(8'h44, 1'b1, -1);
        idle(20);
        check("overrun_count_after", {16'd0, ov_n}, 32'd2);

        // Short glitch on idle line.
        snap_pe = pe_n; snap_fe = fe_n; snap_ov = ov_n; snap_out = nout_n;
        @(negedge clk);
        rxd_n = 1'b0;
        repeat (6) @(negedge clk);
        rxd_n = 1'b1;
        idle(60);
        check("glitch_busy", {31'd0, busy_n}, 32'd0);
        check("glitch_no_output", nout_n, snap_out);
        check("glitch_counts", {pe_n ^ snap_pe, (fe_n ^ snap_fe) | (ov_n ^ snap_ov)}, 32'd0);

        // Mid-bit spike on data bit 2 is outvoted.
        exp_n.push_back({4'b0000, 8'hC3});
        send_n(8'hC3, 1'b1, 3);
        idle(20);

        // Reset during data bit 4 discards the frame.
        drive(1'b0, 16'h0000, 5, -1);
        @(negedge clk);
        rxd_n = 1'b1;
        reset = 1'b1;
        idle(3);
        check_reset_n("rst_mid");
        reset = 1'b0;
        idle(40);
        exp_n.push_back({4'b0000, 8'hF0});
        send_n(8'hF0, 1'b1, -1);
        idle(30);

        for (int i = 0; i < 200; i++) begin
            if (exp_n.size() == 0 && exp_e.size() == 0) break;
            @(negedge clk);
        end
        check("pending_n", exp_n.size(), 0);
        check("pending_e", exp_e.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
Parametrised UART receiver. It generalises the existing 8N1 receiver to configurable data width, parity mode and stop-bit count. Each bit is sampled three times around mid-bit and resolved by majority vote. Every received byte is emitted on an AXI-Stream source together with per-frame error flags (parity, framing, overrun, break) and saturating error counters. The receiver never stalls on back-pressure: the sink normally attaches axis_fifo_wrapper, and data the sink cannot accept is dropped and flagged as overrun.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit; must be >= 8 (868 gives 115200 bps at 100 MHz)
DATA_BITS, 8, data bits per frame, 5..9, LSB first on the line
PARITY_MODE, PARITY_NONE, one of PARITY_NONE / PARITY_EVEN / PARITY_ODD (uart_pkg enum)
STOP_BITS, 1, number of stop bits, 1 or 2
CNT_WIDTH, 16, width of each error counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rxd  in  1  asynchronous serial input, idle high
rx_tdata  out  DATA_BITS  received data word
rx_tvalid  out  1  AXIS valid
rx_tready  in  1  AXIS ready
rx_tuser  out  4  flags: [0] parity_err, [1] framing_err, [2] overrun, [3] break
rx_tlast  out  1  tied 1
parity_err_count  out  CNT_WIDTH  saturating count of frames with parity_err
framing_err_count  out  CNT_WIDTH  saturating count of frames with framing_err
overrun_count  out  CNT_WIDTH  saturating count of dropped frames
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: rx_tvalid=0, rx_tdata=0, rx_tuser=0, all counters 0, busy=0, state IDLE, synchroniser flops=1, sticky overrun=0. Reset mid-frame discards the partial frame; no output results from it.
- Synchroniser: rxd passes through a 2-flop synchroniser to give rxd_s. All timing below is relative to rxd_s.
- Sampling: MID=(CLKS_PER_BIT-1)/2. The bit counter runs 0..CLKS_PER_BIT-1 within each bit slot. rxd_s is sampled at MID-1, MID and MID+1; the majority value is the bit decision, valid at counter MID+1.
- Bit slots are contiguous from the start edge; the counter wraps to 0 after CLKS_PER_BIT-1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE: on the first cycle with rxd_s=0, go to START with counter=0.
  - START: decision 1 = glitch; go to IDLE with no output and no counter change. Decision 0 = continue to DATA at the end of the slot.
  - DATA: bit i is stored at shift position i. After bit DATA_BITS-1, go to PARITY if PARITY_MODE != NONE, otherwise go to STOP.
  - PARITY: even mode requires the XOR of data bits and parity bit to be 0; odd mode requires 1. A mismatch sets parity_err.
  - STOP: a decision of 0 on any stop bit sets framing_err. The frame completes at the decision point of the final stop bit, which is mid-bit. The rest of that slot is not waited out; this allows resync on back-to-back frames.
- Completion: the next state is BREAK_WAIT if break is set, otherwise IDLE.
  - break = all data bits 0, parity bit (if present) 0, and framing_err set.
  - BREAK_WAIT holds until rxd_s=1, then goes to IDLE.
- Output latency: rx_tvalid rises on the cycle after the completion decision cycle.
- Output register (single entry):
  - rx_tvalid stays high until rx_tvalid && rx_tready.
  - Frame completes while rx_tvalid=1 and rx_tready=0: the new frame is dropped, overrun_count increments, and the sticky overrun bit is set.
  - Frame completes in the same cycle the held word is accepted: the new word loads and no overrun occurs.
  - rx_tuser[2] = sticky overrun at load time; the sticky bit clears on that load.
- Frames with errors are still emitted; the flags describe them.
- Counters increment by 1 at completion, or at the drop for overrun, and saturate at all-ones (no wrap).
- Widths: rx_tdata is exactly DATA_BITS wide. With DATA_BITS=9, bit 8 is the last data bit on the line.

Decomposition:
- uart_pkg holds:
  - parity_mode_t enum: PARITY_NONE, PARITY_EVEN, PARITY_ODD
  - uart_rx_state_t enum
  - tuser index constants: TUSER_PARITY=0, TUSER_FRAMING=1, TUSER_OVERRUN=2, TUSER_BREAK=3
- Sub-module uart_bit_sampler owns the bit counter, the three-point majority vote and the slot-end/decision strobes. The top-level FSM consumes those strobes.

Test Plan:
- CLKS_PER_BIT=16, 8N1. Drive 0xA5 with rx_tready=1. Expect rx_tdata=0xA5, rx_tuser=0, rx_tvalid high for 1 cycle, and rx_tvalid rising at start edge + 2 synchroniser cycles + 9×16 + 8 + 1 cycles.
- PARITY_EVEN. Send 0x07 with parity bit 1 -> tuser=0. Send 0x07 with parity bit 0 -> tuser[0]=1 and parity_err_count=1.
- Stop bit driven 0 on byte 0x3C -> tdata=0x3C, tuser[1]=1, framing_err_count=1. Then a line held low for 2 frame times -> tuser=0b1010 (break + framing), busy stays high until the line returns high, and the next byte 0x55 is received cleanly.
- rx_tready=0; send 0x11, 0x22, 0x33. Then raise rx_tready -> 0x11 is accepted, 0x22 and 0x33 are dropped, overrun_count=2. The next byte 0x44 arrives with tuser[2]=1.
- 6-cycle low glitch on an idle line -> no rx_tvalid and no counter change. A 1-cycle spike at the MID sample of a data bit -> the majority vote rejects it and the byte is correct.
- Reset asserted at data bit 4 of a frame -> all outputs at reset values. A complete frame 0xF0 after reset releases is received correctly.
